pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use bubble, branch redirect,
// data-memory wait with timeout, post-reset clear. Optional perf counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int REG_ADDR_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic                  id_branch_i,
  input  logic                  ex_rmem_en_i,
  input  logic [REG_ADDR_W-1:0] ex_wreg_addr_i,
  input  logic                  dmem_req_i,
  input  logic                  dmem_ready_i,
  output logic                  pc_stall_o,
  output logic                  if_id_stall_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_stall_o,
  output logic                  id_ex_flush_o,
  output logic                  ex_mem_stall_o,
  output logic                  mem_wb_flush_o,
  output logic                  pc_sel_o,
  output logic                  mem_err_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           redirect_cnt_o
`endif
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic lu_hz;
  logic mem_hold;
  logic timeout;
  logic wait_hold;
  logic hold_all;
  logic decode;
  logic boot;
  logic err;

  assign lu_hz = ex_rmem_en_i & (ex_wreg_addr_i != '0) &
                 ((id_rs1_used_i & (id_rs1_addr_i == ex_wreg_addr_i)) |
                  (id_rs2_used_i & (id_rs2_addr_i == ex_wreg_addr_i)));
  assign mem_hold  = dmem_req_i & ~dmem_ready_i;
  assign timeout   = (MEM_TIMEOUT != 0) && (cnt == CNT_LIMIT);
  assign wait_hold = ~dmem_ready_i & ~timeout;

  // Select which decode applies this cycle; the release cycle of a wait
  // falls back to the hazard/branch decode without re-checking mem_hold.
  always_comb begin
    hold_all = 1'b0;
    decode   = 1'b0;
    boot     = 1'b0;
    err      = 1'b0;
    case (state)
      BOOT: boot = 1'b1;
      RUN: begin
        if (mem_hold) hold_all = 1'b1;
        else          decode   = 1'b1;
      end
      MEM_WAIT: begin
        if (wait_hold) begin
          hold_all = 1'b1;
        end else begin
          decode = 1'b1;
          err    = timeout & ~dmem_ready_i;
        end
      end
      default: boot = 1'b1;
    endcase
  end

  // A taken branch is ignored while a load-use bubble is inserted.
  assign pc_stall_o     = hold_all | (decode & lu_hz);
  assign if_id_stall_o  = hold_all | (decode & lu_hz);
  assign if_id_flush_o  = boot | (decode & ~lu_hz & id_branch_i);
  assign id_ex_stall_o  = hold_all;
  assign id_ex_flush_o  = boot | (decode & lu_hz);
  assign ex_mem_stall_o = hold_all;
  assign mem_wb_flush_o = hold_all;
  assign pc_sel_o       = decode & ~lu_hz & id_branch_i;
  assign mem_err_o      = err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
      cnt   <= '0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (mem_hold) begin
            state <= MEM_WAIT;
            cnt   <= CNT_ONE;
          end
        end
        MEM_WAIT: begin
          if (wait_hold) begin
            // With no timeout the count is irrelevant, so keep it from wrapping.
            if (MEM_TIMEOUT != 0) cnt <= cnt + CNT_ONE;
          end else begin
            state <= RUN;
            cnt   <= '0;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o    <= '0;
      redirect_cnt_o <= '0;
    end else begin
      if (pc_stall_o && (state != BOOT) && (stall_cnt_o != 32'hFFFF_FFFF))
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if (pc_sel_o && (redirect_cnt_o != 32'hFFFF_FFFF))
        redirect_cnt_o <= redirect_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: two instances (timeout 4 and no timeout)
// share random/directed stimulus and are compared to a cycle-level reference model.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_wreg_addr;
  logic       id_rs1_used, id_rs2_used, id_branch, ex_rmem_en;
  logic       dmem_req, dmem_ready;

  logic [8:0] obs [2];
  logic [31:0] stall_cnt [2];
  logic [31:0] redirect_cnt [2];

  int checks = 0;
  int fails  = 0;

  // Reference model state, per instance
  int tmo [2] = '{4, 0};
  bit m_boot [2];
  bit m_wait [2];
  int m_waited [2];
  int m_stall [2];
  int m_redir [2];

  localparam logic [8:0] BOOT_V  = 9'b001010000;
  localparam logic [8:0] STALL_V = 9'b110101100;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic o_pcs, o_ifs, o_iff, o_ids, o_idf, o_exs, o_mwf, o_sel, o_err;
    pipe_ctrl #(.MEM_TIMEOUT(gi == 0 ? 4 : 0), .REG_ADDR_W(5)) dut (
      .clk            (clk),
      .rst            (rst),
      .id_rs1_addr_i  (id_rs1_addr),
      .id_rs2_addr_i  (id_rs2_addr),
      .id_rs1_used_i  (id_rs1_used),
      .id_rs2_used_i  (id_rs2_used),
      .id_branch_i    (id_branch),
      .ex_rmem_en_i   (ex_rmem_en),
      .ex_wreg_addr_i (ex_wreg_addr),
      .dmem_req_i     (dmem_req),
      .dmem_ready_i   (dmem_ready),
      .pc_stall_o     (o_pcs),
      .if_id_stall_o  (o_ifs),
      .if_id_flush_o  (o_iff),
      .id_ex_stall_o  (o_ids),
      .id_ex_flush_o  (o_idf),
      .ex_mem_stall_o (o_exs),
      .mem_wb_flush_o (o_mwf),
      .pc_sel_o       (o_sel),
      .mem_err_o      (o_err)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .stall_cnt_o    (stall_cnt[gi]),
      .redirect_cnt_o (redirect_cnt[gi])
`endif
    );
    assign obs[gi] = {o_pcs, o_ifs, o_iff, o_ids, o_idf, o_exs, o_mwf, o_sel, o_err};
`ifndef PIPE_CTRL_PERF_EN
    assign stall_cnt[gi]    = 32'd0;
    assign redirect_cnt[gi] = 32'd0;
`endif
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // Expected outputs from the pipeline rules: boot clear, memory hold with a
  // bounded number of stalled cycles, then load-use over branch.
  task automatic predict(input int k, output logic [8:0] e, output bit nw, output int nc);
    bit hz, dec, to;
    hz = ex_rmem_en && (ex_wreg_addr != 0) &&
         ((id_rs1_used && id_rs1_addr == ex_wreg_addr) ||
          (id_rs2_used && id_rs2_addr == ex_wreg_addr));
    e = '0; dec = 0; nw = m_wait[k]; nc = m_waited[k];
    if (m_boot[k]) begin
      e = BOOT_V;
      nw = 0; nc = 0;
    end else if (!m_wait[k]) begin
      if (dmem_req && !dmem_ready) begin
        e = STALL_V; nw = 1; nc = 1;
      end else dec = 1;
    end else begin
      to = (tmo[k] != 0) && (m_waited[k] == tmo[k]);
      if (!dmem_ready && !to) begin
        e = STALL_V; nc = m_waited[k] + 1;
      end else begin
        dec = 1; e[0] = to && !dmem_ready; nw = 0; nc = 0;
      end
    end
    if (dec) begin
      if (hz) begin e[8] = 1; e[7] = 1; e[4] = 1; end
      else if (id_branch) begin e[1] = 1; e[6] = 1; end
    end
  endtask

  task automatic step();
    logic [8:0] e [2];
    bit nw [2];
    int nc [2];
    #3;
    for (int k = 0; k < 2; k++) begin
      predict(k, e[k], nw[k], nc[k]);
      check_value($sformatf("outputs_t%0d", tmo[k]), {23'd0, obs[k]}, {23'd0, e[k]});
`ifdef PIPE_CTRL_PERF_EN
      check_value($sformatf("stall_cnt_t%0d", tmo[k]), stall_cnt[k], m_stall[k]);
      check_value($sformatf("redirect_cnt_t%0d", tmo[k]), redirect_cnt[k], m_redir[k]);
`endif
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        m_boot[k] = 0; m_wait[k] = nw[k]; m_waited[k] = nc[k];
        if (e[k][8]) m_stall[k]++;
        if (e[k][1]) m_redir[k]++;
      end
    end
    #1;
  endtask

  // Assert reset mid-cycle; outputs must change without waiting for a clock edge.
  task automatic apply_reset(input int n);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_value($sformatf("async_rst_t%0d", tmo[k]), {23'd0, obs[k]}, {23'd0, BOOT_V});
`ifdef PIPE_CTRL_PERF_EN
      check_value($sformatf("rst_stall_cnt_t%0d", tmo[k]), stall_cnt[k], 32'd0);
      check_value($sformatf("rst_redirect_cnt_t%0d", tmo[k]), redirect_cnt[k], 32'd0);
`endif
      m_boot[k] = 1; m_wait[k] = 0; m_waited[k] = 0; m_stall[k] = 0; m_redir[k] = 0;
    end
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic idle();
    id_rs1_addr = 0; id_rs2_addr = 0; ex_wreg_addr = 0;
    id_rs1_used = 0; id_rs2_used = 0; id_branch = 0; ex_rmem_en = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic load_use();
    idle();
    ex_rmem_en = 1; ex_wreg_addr = 5; id_rs2_addr = 5; id_rs2_used = 1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    apply_reset(3);
    idle(); step();          // boot cycle: both flushes still asserted
    step();                  // quiet RUN cycle

    load_use(); step();
    idle(); id_branch = 1; step(); step();
    idle(); dmem_req = 1; repeat (3) step();
    dmem_ready = 1; step();
    idle(); step();
`ifdef PIPE_CTRL_PERF_EN
    check_value("perf_stall_total", stall_cnt[0], 32'd4);
    check_value("perf_redirect_total", redirect_cnt[0], 32'd2);
`endif

    load_use(); ex_wreg_addr = 0; step();
    load_use(); id_rs2_used = 0; step();
    load_use(); id_branch = 1; step();
    idle(); id_branch = 1; step();
    idle(); step();

    // Permanent memory hold: timeout instance cycles through err pulses,
    // the no-timeout instance stays stalled throughout.
    idle(); dmem_req = 1; repeat (1000) step();
    dmem_ready = 1; step();
    idle(); step();

    idle(); dmem_req = 1; step(); step();
    apply_reset(1);
    idle(); step(); step();

    for (int i = 0; i < 3000; i++) begin
      id_rs1_addr  = 5'($urandom_range(0, 3));
      id_rs2_addr  = 5'($urandom_range(0, 3));
      ex_wreg_addr = 5'($urandom_range(0, 3));
      id_rs1_used  = 1'($urandom_range(0, 1));
      id_rs2_used  = 1'($urandom_range(0, 1));
      id_branch    = ($urandom_range(0, 3) == 0);
      ex_rmem_en   = ($urandom_range(0, 2) == 0);
      dmem_req     = ($urandom_range(0, 9) < 3);
      dmem_ready   = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 299) == 0) apply_reset(1 + $urandom_range(0, 1));
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
